// File: rtl/mips_dmem_wbuf.sv
// Data-memory responder for the pipelined MIPS core.
// Stores land in a small circular write buffer that drains into a word RAM
// at a throttled rate; loads are served combinationally, forwarding from the
// newest matching buffered store before falling back to the RAM array.
module mips_dmem_wbuf #(
  parameter int DEPTH     = 64,
  parameter int WB_DEPTH  = 4,
  parameter int DRAIN_GAP = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        memwrite,
  input  logic [31:0]                 addr,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  output logic [$clog2(WB_DEPTH):0]   wb_count,
  output logic                        wb_full,
  output logic                        overflow,
  output logic                        misalign
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GC_W  = (DRAIN_GAP > 0) ? $clog2(DRAIN_GAP + 1) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WB_DEPTH);
  localparam logic [GC_W-1:0]  GAP_LD   = GC_W'(DRAIN_GAP);

  // Storage: RAM array and buffer entries carry no reset (RAM survives reset).
  logic [31:0]      ram_q     [DEPTH];
  logic [IDX_W-1:0] wb_idx_q  [WB_DEPTH];
  logic [31:0]      wb_data_q [WB_DEPTH];

  // Control state
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [GC_W-1:0]  gc_q, gc_d;
  logic             ovf_q, ovf_d;
  logic             mis_q, mis_d;

  logic [IDX_W-1:0] idx;
  logic             aligned;
  logic             full;
  logic             drain;
  logic             push;
  logic [PTR_W-1:0] slot;

  // Upper address bits wrap modulo DEPTH and are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^addr[31:IDX_W+2];

  assign idx     = addr[IDX_W+1:2];
  assign aligned = (addr[1:0] == 2'b00);
  assign full    = (count_q == FULL_CNT);
  assign drain   = (count_q != '0) && (gc_q == '0);
  // A drain in the same cycle frees the head slot, so a full buffer can still accept.
  assign push    = memwrite && aligned && (!full || drain);

  // Next-state logic for pointers, occupancy, gap counter and sticky flags
  always_comb begin
    head_d  = drain ? head_q + PTR_W'(1) : head_q;
    tail_d  = push  ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q;
    case ({push, drain})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    gc_d = gc_q;
    if (drain) begin
      gc_d = GAP_LD;
    end else if (gc_q != '0) begin
      gc_d = gc_q - GC_W'(1);
    end
    ovf_d = ovf_q || (memwrite && aligned && full && !drain);
    mis_d = mis_q || (memwrite && !aligned);
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      gc_q    <= '0;
      ovf_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      gc_q    <= gc_d;
      ovf_q   <= ovf_d;
      mis_q   <= mis_d;
    end
  end

  // Buffer entry capture and RAM write-back; suppressed while reset is asserted
  always_ff @(posedge clk) begin
    if (reset && push) begin
      wb_idx_q[tail_q]  <= idx;
      wb_data_q[tail_q] <= writedata;
    end
    if (reset && drain) begin
      ram_q[wb_idx_q[head_q]] <= wb_data_q[head_q];
    end
  end

  // Load path: walk oldest to newest so the newest matching entry wins
  always_comb begin
    readdata = ram_q[idx];
    slot     = head_q;
    for (int i = 0; i < WB_DEPTH; i++) begin
      slot = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (wb_idx_q[slot] == idx)) begin
        readdata = wb_data_q[slot];
      end
    end
  end

  assign wb_count = count_q;
  assign wb_full  = full;
  assign overflow = ovf_q;
  assign misalign = mis_q;

endmodule

// File: doc/mips_dmem_wbuf.md
# mips_dmem_wbuf

Data-memory responder for the pipelined MIPS core: it sits on the core's data port (address, store data, store strobe, load data) and serves loads combinationally. Stores are accepted one per cycle into a WB_DEPTH-entry write buffer. The buffer drains into a word RAM no faster than one entry every DRAIN_GAP+1 cycles, modelling a slow array. Loads are forwarded from the newest matching buffered store, so the core always sees single-cycle memory semantics.

## Interface
- DEPTH, 64: RAM size in 32-bit words; power of two.
- WB_DEPTH, 4: write-buffer entries; power of two, ≥2.
- DRAIN_GAP, 2: minimum idle cycles between successive RAM writes; 0 allows one drain per cycle.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- memwrite  in  1  store strobe from the core's MEM stage.
- addr  in  32  byte address (core ALU result); word index = addr[log2(DEPTH)+1:2], upper bits ignored (wrap modulo DEPTH).
- writedata  in  32  store data.
- readdata  out  32  load data, combinational from addr.
- wb_count  out  log2(WB_DEPTH)+1  entries currently buffered.
- wb_full  out  1  wb_count == WB_DEPTH.
- overflow  out  1  sticky: a store was dropped.
- misalign  out  1  sticky: a store with addr[1:0] != 0 was seen.

## Operation
- Write buffer: circular FIFO of {word index, data}; head/tail pointers wrap at WB_DEPTH.
- Push: a store pushes at the clock edge when all of the following hold:
  - memwrite=1,
  - addr[1:0]=00,
  - the buffer is not full, or a drain occurs in the same cycle.
- Misaligned store: not pushed; misalign set; nothing else changes.
- Full, no drain that cycle: store dropped; overflow set; buffer unchanged.
- Drain engine: gap counter gc.
  - If wb_count>0 and gc==0: the head entry is written to RAM at the edge, head advances, and gc loads DRAIN_GAP.
  - Otherwise, if gc>0, gc decrements.
  - gc keeps counting while the buffer is empty.
- Simultaneous push and drain: wb_count unchanged. This is legal when full; the pushed entry takes the freed slot.
- readdata: scan the valid entries from newest to oldest; return the data of the first entry whose index matches. With no match, return RAM[index].
- Duplicate addresses in the buffer: the newest entry wins on reads; entries drain in order, so RAM ends up with the newest value.
- Load and store to the same address in the same cycle: readdata returns the pre-store value (the store is visible from the next cycle).
- Reset (reset=0 at an edge), including mid-drain:
  - head, tail, wb_count, gc, overflow and misalign are cleared;
  - pending buffered stores are discarded;
  - RAM contents are kept and are not initialised.
- readdata for a never-written word is undefined.

## Timing
- Store accepted at edge T: visible on readdata from cycle T+1 (via forwarding).
- With an empty buffer and gc==0 at the store, that entry drains to RAM at edge T+1.
- Back-to-back stores: the drain throughput is 1/(DRAIN_GAP+1) per cycle. With DRAIN_GAP=2, WB_DEPTH=4 and continuous stores, wb_full first asserts after edge 6 (6 pushes, 2 drains).
- wb_count, wb_full, overflow and misalign are registered and update at the edge.
- readdata has no pipeline latency: a purely combinational path from addr through the buffer compare and RAM read.
- Reset values:
  - readdata = RAM[index];
  - wb_count = 0, wb_full = 0, overflow = 0, misalign = 0.

## Test plan
- Single store then load: store 0xDEADBEEF to 0x10 at T; load 0x10 at T+1 returns 0xDEADBEEF (forwarded), and still returns it at T+10 (from RAM, wb_count=0).
- Same-cycle hazard: RAM[4]=0x1111 (byte 0x10), then store 0x2222 to 0x10 with addr=0x10 held. readdata = 0x1111 during the store cycle and 0x2222 the next cycle.
- Duplicate forwarding: with DRAIN_GAP=7, store 0xA to 0x20, then 0xB to 0x20 back-to-back; load 0x20 returns 0xB. After the buffer empties, RAM[8]=0xB.
- Full/overflow: DRAIN_GAP=2, WB_DEPTH=4, 8 consecutive stores of data k to address 4k (k=0..7).
  - wb_full rises after edge 6.
  - Stores on cycles where full and no drain occurs are dropped and overflow=1.
  - Every non-dropped word reads back correctly.
- Misaligned store: store 0x55 to 0x13. misalign=1, wb_count stays 0, and RAM[4] is unchanged.
- Reset mid-operation: fill 3 entries with DRAIN_GAP=7, then pulse reset=0 for one cycle.
  - wb_count=0, overflow=0, misalign=0.
  - Undrained addresses read their old RAM values.
  - The next store drains at the following edge.
